// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the decoder, datapath and register file.
package regfile_pkg;

  localparam int unsigned WidthAddr = 5;
  localparam int unsigned WidthData = 32;
  localparam int unsigned NRegs     = 2 ** WidthAddr;

  typedef logic [WidthAddr-1:0] reg_addr_t;
  typedef logic [WidthData-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, released by either writeback port.
module regfile_scoreboard #(
  parameter int unsigned WIDTH_ADDR = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we3,
  input  logic [WIDTH_ADDR-1:0] wa3,
  input  logic                  we4,
  input  logic [WIDTH_ADDR-1:0] wa4,
  input  logic [WIDTH_ADDR-1:0] ra1,
  input  logic [WIDTH_ADDR-1:0] ra2,
  input  logic                  iss_en,
  input  logic [WIDTH_ADDR-1:0] iss_wa,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  hazard
);

  localparam int unsigned Depth = 2 ** WIDTH_ADDR;

  logic [Depth-1:0] busy_q, busy_d, clr, busy_eff;
  logic             iss_ok;

  always_comb begin
    clr = '0;
    if (we3) clr[wa3] = 1'b1;
    if (we4) clr[wa4] = 1'b1;
    busy_eff = busy_q & ~clr;

    // Outputs forced low while reset is held.
    busy1  = rst_n & busy_eff[ra1];
    busy2  = rst_n & busy_eff[ra2];
    hazard = rst_n & iss_en & (busy_eff[ra1] | busy_eff[ra2] | busy_eff[iss_wa]);
    iss_ok = iss_en & ~hazard & (iss_wa != '0);

    // Set beats a same-cycle clear of the destination.
    busy_d = busy_q & ~clr;
    if (iss_ok) busy_d[iss_wa] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-write/two-read register file with optional write bypass, write-conflict flag and
// issue-time hazard scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH_ADDR = WidthAddr,
  parameter int unsigned WIDTH_DATA = WidthData,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH_ADDR-1:0] ra1,
  input  logic [WIDTH_ADDR-1:0] ra2,
  output logic [WIDTH_DATA-1:0] rd1,
  output logic [WIDTH_DATA-1:0] rd2,
  input  logic                  we3,
  input  logic [WIDTH_ADDR-1:0] wa3,
  input  logic [WIDTH_DATA-1:0] wd3,
  input  logic                  we4,
  input  logic [WIDTH_ADDR-1:0] wa4,
  input  logic [WIDTH_DATA-1:0] wd4,
  input  logic                  iss_en,
  input  logic [WIDTH_ADDR-1:0] iss_wa,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  hazard,
  output logic                  err_wconf
);

  localparam int unsigned Depth = 2 ** WIDTH_ADDR;

  logic [WIDTH_DATA-1:0] regf_q [Depth];
  logic                  err_wconf_q;
  logic                  wconf;

  assign wconf     = we3 && we4 && (wa3 == wa4) && (wa3 != '0);
  assign err_wconf = err_wconf_q;

  // Port 4 is written last so it wins an address conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) regf_q[i] <= '0;
      err_wconf_q <= 1'b0;
    end else begin
      if (we3 && wa3 != '0) regf_q[wa3] <= wd3;
      if (we4 && wa4 != '0) regf_q[wa4] <= wd4;
      if (wconf) err_wconf_q <= 1'b1;
    end
  end

  function automatic logic [WIDTH_DATA-1:0] read_port(input logic [WIDTH_ADDR-1:0] ra);
    logic [WIDTH_DATA-1:0] val;
    val = '0;
    if (rst_n && ra != '0) begin
      if (BYPASS != 0 && we4 && wa4 == ra)      val = wd4;
      else if (BYPASS != 0 && we3 && wa3 == ra) val = wd3;
      else                                      val = regf_q[ra];
    end
    return val;
  endfunction

  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
  end

  regfile_scoreboard #(
    .WIDTH_ADDR(WIDTH_ADDR)
  ) u_scoreboard (
    .clk    (clk),
    .rst_n  (rst_n),
    .we3    (we3),
    .wa3    (wa3),
    .we4    (we4),
    .wa4    (wa4),
    .ra1    (ra1),
    .ra2    (ra2),
    .iss_en (iss_en),
    .iss_wa (iss_wa),
    .busy1  (busy1),
    .busy2  (busy2),
    .hazard (hazard)
  );

endmodule
